ca_gen_controller: RTL

Sequencer for the 1-D cellular-automaton datapath: owns the active rule byte, produces the initial row (single centre cell or pseudo-random), and paces generation advances through a valid/ready handshake with the cell-row array. Sits between the board switches/buttons and the row array, whose per-cell rule lookups index the `rule` bus this block drives.

---
 rtl/ca_pkg.sv | 35 +++
 rtl/ca_prescaler.sv | 38 +++
 rtl/ca_gen_controller.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ca_pkg.sv
// Shared types and constants for the cellular-automaton generation controller.
package ca_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEED      = 3'd1,
        PAUSE     = 3'd2,
        RUN       = 3'd3,
        RUN_WAIT  = 3'd4,
        STEP_WAIT = 3'd5
    } ca_state_t;

    localparam logic [7:0]  RULE_30   = 8'd30;
    localparam logic [7:0]  RULE_54   = 8'd54;
    localparam logic [7:0]  RULE_60   = 8'd60;
    localparam logic [7:0]  RULE_182  = 8'd182;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [7:0] rule_map(input logic [1:0] sel);
        logic [7:0] r;
        case (sel)
            2'b00:   r = RULE_30;
            2'b01:   r = RULE_54;
            2'b10:   r = RULE_60;
            default: r = RULE_182;
        endcase
        return r;
    endfunction

    // Fibonacci form, taps 16,14,13,11; feedback enters at bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

endpackage

// File: rtl/ca_prescaler.sv
// Run-rate prescaler: counts while enabled and emits a one-cycle tick at the speed-selected limit.
module ca_prescaler
    import ca_pkg::*;
#(
    parameter int DIV_W = 24
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       enable,
    input  logic [1:0] speed,
    output logic       tick
);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] limit;

    always_comb begin
        limit = '0;
        case (speed)
            2'b00:   limit = {DIV_W{1'b1}};
            2'b01:   limit = {2'b00, {(DIV_W-2){1'b1}}};
            2'b10:   limit = {4'b0000, {(DIV_W-4){1'b1}}};
            default: limit = '0;
        endcase
    end

    assign tick = enable && (count == limit);

    always_ff @(posedge clk) begin
        if (!reset_n || clear || tick) begin
            count <= '0;
        end else if (enable) begin
            count <= count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/ca_gen_controller.sv
// Generation sequencer: owns the rule byte, builds the seed row and paces
// generation advances to the cell-row array over valid/ready handshakes.
module ca_gen_controller
    import ca_pkg::*;
#(
    parameter int CELLS = 64,
    parameter int DIV_W = 24,
    parameter int GEN_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       sw,
    input  logic [1:0]       speed,
    input  logic             seed_req,
    input  logic             step_req,
    input  logic             run_toggle,
    input  logic [GEN_W-1:0] gen_limit,
    output logic             seed_valid,
    input  logic             seed_ready,
    output logic [CELLS-1:0] seed_data,
    output logic             step_valid,
    input  logic             step_ready,
    output logic [7:0]       rule,
    output logic [GEN_W-1:0] gen_count,
    output logic             running,
    output logic             done,
    output ca_state_t        state
);

    // Handshakes: a transfer happens on every rising edge where valid and
    // ready are both high; valid, once raised, holds until that transfer and
    // its payload stays stable; ready may lead valid.

    logic [15:0]      lfsr;
    logic [CELLS-1:0] seed_row;
    logic [GEN_W-1:0] gen_next;
    logic             limit_hit;
    logic             tick;
    logic             stop_pend;
    logic             unused_sw;

    assign unused_sw = sw[3];

    ca_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state != RUN),
        .enable  (state == RUN),
        .speed   (speed),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    always_comb begin
        seed_row = '0;
        for (int i = 0; i < CELLS; i++) begin
            seed_row[i] = sw[2] ? lfsr[4'(i % 16)] : (i == CELLS / 2);
        end
    end

    assign gen_next  = gen_count + GEN_W'(1);
    assign limit_hit = (gen_limit != '0) && (gen_next == gen_limit);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            seed_valid <= 1'b0;
            step_valid <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b0;
            gen_count  <= '0;
            seed_data  <= '0;
            stop_pend  <= 1'b0;
            rule       <= rule_map(sw[1:0]);
        end else begin
            case (state)
                IDLE: begin
                    if (seed_req) begin
                        state      <= SEED;
                        seed_valid <= 1'b1;
                        seed_data  <= seed_row;
                    end
                end
                SEED: begin
                    if (seed_ready) begin
                        state      <= PAUSE;
                        seed_valid <= 1'b0;
                        gen_count  <= '0;
                        done       <= 1'b0;
                        rule       <= rule_map(sw[1:0]);
                    end
                end
                PAUSE: begin
                    if (seed_req) begin
                        state      <= SEED;
                        seed_valid <= 1'b1;
                        seed_data  <= seed_row;
                    end else if (step_req) begin
                        state      <= STEP_WAIT;
                        step_valid <= 1'b1;
                    end else if (run_toggle && !done) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (seed_req) begin
                        state      <= SEED;
                        running    <= 1'b0;
                        seed_valid <= 1'b1;
                        seed_data  <= seed_row;
                    end else if (run_toggle) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end else if (tick) begin
                        state      <= RUN_WAIT;
                        step_valid <= 1'b1;
                    end
                end
                RUN_WAIT, STEP_WAIT: begin
                    if (state == RUN_WAIT && run_toggle) begin
                        stop_pend <= 1'b1;
                    end
                    if (step_ready) begin
                        step_valid <= 1'b0;
                        gen_count  <= gen_next;
                        stop_pend  <= 1'b0;
                        // A toggle on the accepting cycle counts as a stop request too.
                        if (limit_hit) begin
                            state   <= PAUSE;
                            done    <= 1'b1;
                            running <= 1'b0;
                        end else if (state == RUN_WAIT && !stop_pend && !run_toggle) begin
                            state <= RUN;
                        end else begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    seed_valid <= 1'b0;
                    step_valid <= 1'b0;
                    running    <= 1'b0;
                end
            endcase
        end
    end

endmodule
